method_test_driver: RTL and testbench
=====================================

// Module: method_test_driver
// PURPOSE
//  Synthesizable stimulus/check stage directly upstream of a Synthesijer-generated DUT method port.
//  Generates a windowed DUT reset and drives the method's req/busy handshake.
//  Samples the boolean return value and reports pass/fail/timeout.
//  Replaces hand-written counter logic in per-sample bench tops; also usable on FPGA with LED/UART reporting.
// PARAMETERS
//  CNT_W        32         width of cycle counter and all count parameters
//  RST_START    3          first cycle (inclusive) dut_reset is high
//  RST_END      8          last cycle (inclusive) dut_reset is high
//  REQ_DELAY    100        test_req rises on the cycle after counter exceeds this value
//  GRACE        5          cycles after req rise in which busy may still be low without completing
//  TIMEOUT      200000000  counter value above which the run is abandoned
// PORTS
//  clk          in   1      sole clock
//  reset        in   1      synchronous, active-high
//  dut_reset    out  1      reset to DUT
//  test_req     out  1      method request, level
//  test_busy    in   1      method busy from DUT
//  test_return  in   1      method return value (boolean) from DUT
//  done         out  1      run finished (sticky until reset)
//  pass         out  1      valid when done: return sampled 1 and no timeout
//  timed_out    out  1      valid when done: TIMEOUT reached first
//  cycles       out  CNT_W  only with MTD_CYCLES_EN: req-to-completion cycle count
// BEHAVIOUR
//  - Reset: counter=0; dut_reset=0, test_req=0, done=0, pass=0, timed_out=0, cycles=0; state=RST_WIN.
//  - Counter: +1 every cycle while not DONE; saturates at 2^CNT_W-1; frozen in DONE.
//  - dut_reset registered: high exactly when RST_START <= counter <= RST_END.
//  - FSM (all outputs registered, one-cycle transitions):
//    RST_WIN -> WAIT_REQ once counter > RST_END.
//    WAIT_REQ: counter > REQ_DELAY -> REQ; test_req=1 from next cycle on.
//    REQ: busy=1 -> BUSY. Busy still 0 after GRACE cycles in REQ -> DONE (zero-latency method).
//    BUSY: busy=0 -> DONE.
//    DONE: test_req=0, done=1; pass<=test_return sampled on the completion cycle; timed_out=0.
//  - test_req held high continuously in REQ and BUSY; it never pulses.
//  - Timeout: counter > TIMEOUT in any state other than DONE -> DONE with pass=0, timed_out=1.
//  - Completion and timeout in the same cycle: completion wins (pass from test_return, timed_out=0).
//  - Busy glitch (1->0->1) in BUSY: first low cycle completes; later busy ignored.
//  - RST_START > RST_END: dut_reset never asserts; FSM proceeds normally.
//  - REQ_DELAY <= RST_END: req rises the cycle after leaving RST_WIN.
//  - reset mid-run: immediate return to reset values; whole sequence restarts, incl. dut_reset window.
// CONFIGURATION
//  MTD_CYCLES_EN defined: cycles counts the cycles test_req is high (req rise to completion).
//   It freezes in DONE and equals 0 on timeout.
//  MTD_CYCLES_EN undefined: cycles port and counter absent; all else identical.
// STRUCTURE
//  method_test_pkg holds:
//   - mtd_state_t enum (RST_WIN, WAIT_REQ, REQ, BUSY, DONE)
//   - default CNT_W constant
//   - grace-counter width function (clog2(GRACE+1))
//  One sub-module, mtd_timer: saturating CNT_W counter with enable/clear, instanced for the
//   main counter and (under MTD_CYCLES_EN) the cycle measurement.
// TESTING
//  T1 model DUT busy=1 for 50 cycles after req, return=1 -> dut_reset high cycles 3..8;
//     req rises at cycle 102; done=1, pass=1, timed_out=0; cycles=51 with MTD_CYCLES_EN.
//  T2 same with return=0 -> done=1, pass=0, timed_out=0.
//  T3 busy never asserts, return=1 -> completion at GRACE=5 cycles after req, pass=1.
//  T4 TIMEOUT=1000, busy stuck high -> done at counter 1001, pass=0, timed_out=1, test_req=0.
//  T5 busy falls on exactly the timeout cycle, return=1 -> pass=1, timed_out=0.
//  T6 reset pulsed at counter 150 while BUSY -> all outputs 0 next cycle;
//     dut_reset window repeats; run then completes as T1.

Source files
------------

// File: rtl/method_test_pkg.sv
// Shared types and helpers for the method test driver: FSM state encoding,
// default counter width and grace-counter sizing.
package method_test_pkg;

    localparam int MTD_CNT_W = 32;

    typedef enum logic [2:0] {
        RST_WIN  = 3'd0,
        WAIT_REQ = 3'd1,
        REQ      = 3'd2,
        BUSY     = 3'd3,
        DONE     = 3'd4
    } mtd_state_t;

    // Width able to hold 0..GRACE; never narrower than one bit.
    function automatic int grace_w(input int grace);
        return (grace < 1) ? 1 : $clog2(grace + 1);
    endfunction

endpackage

// File: rtl/mtd_timer.sv
// Saturating up-counter with synchronous clear (priority over enable).
module mtd_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en && (q != {CNT_W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/method_test_driver.sv
// Stimulus/check stage for a generated method port: windowed DUT reset, req/busy
// handshake, pass/timeout report. Define MTD_CYCLES_EN to add the cycles output.
module method_test_driver
    import method_test_pkg::*;
#(
    parameter int             CNT_W     = MTD_CNT_W,
    parameter logic [CNT_W-1:0] RST_START = 3,
    parameter logic [CNT_W-1:0] RST_END   = 8,
    parameter logic [CNT_W-1:0] REQ_DELAY = 100,
    parameter int             GRACE     = 5,
    parameter logic [CNT_W-1:0] TIMEOUT   = 200000000
) (
    input  logic             clk,
    input  logic             reset,
    output logic             dut_reset,
    output logic             test_req,
    input  logic             test_busy,
    input  logic             test_return,
    output logic             done,
    output logic             pass,
    output logic             timed_out
`ifdef MTD_CYCLES_EN
    ,
    output logic [CNT_W-1:0] cycles
`endif
);

    localparam int GW = grace_w(GRACE);
    localparam logic [GW-1:0] G_LAST = (GRACE > 0) ? GW'(GRACE - 1) : '0;

    mtd_state_t       state;
    mtd_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [GW-1:0]    grace_cnt;
    logic             running;
    logic             complete;
    logic             tout_hit;

    assign running = (state != DONE);

    mtd_timer #(.CNT_W(CNT_W)) u_main_timer (
        .clk (clk),
        .rst (reset),
        .en  (running),
        .clr (1'b0),
        .q   (cnt)
    );

    // Value the main counter takes at the next edge, so dut_reset lines up with it.
    assign cnt_nxt = (running && (cnt != {CNT_W{1'b1}})) ? cnt + 1'b1 : cnt;

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        tout_hit  = 1'b0;
        case (state)
            RST_WIN:  if (cnt > RST_END) state_nxt = WAIT_REQ;
            WAIT_REQ: if (cnt > REQ_DELAY) state_nxt = REQ;
            REQ: begin
                if (test_busy) begin
                    state_nxt = BUSY;
                end else if (grace_cnt == G_LAST) begin
                    complete  = 1'b1;
                    state_nxt = DONE;
                end
            end
            BUSY: begin
                if (!test_busy) begin
                    complete  = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = DONE;
        endcase
        // Completion on the same cycle as the timeout takes precedence.
        if (running && (cnt > TIMEOUT) && !complete) begin
            tout_hit  = 1'b1;
            state_nxt = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RST_WIN;
            dut_reset <= 1'b0;
            test_req  <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
            grace_cnt <= '0;
        end else begin
            state     <= state_nxt;
            dut_reset <= (cnt_nxt >= RST_START) && (cnt_nxt <= RST_END);
            test_req  <= (state_nxt == REQ) || (state_nxt == BUSY);
            done      <= (state_nxt == DONE);
            grace_cnt <= (state == REQ) ? grace_cnt + 1'b1 : '0;
            if (complete) begin
                pass <= test_return;
            end
            if (tout_hit) begin
                pass      <= 1'b0;
                timed_out <= 1'b1;
            end
        end
    end

`ifdef MTD_CYCLES_EN
    // Counts every cycle test_req is high, including the completion cycle.
    mtd_timer #(.CNT_W(CNT_W)) u_cycle_timer (
        .clk (clk),
        .rst (reset),
        .en  (test_req),
        .clr (tout_hit),
        .q   (cycles)
    );
`endif

endmodule

// File: tb/tb_method_test_driver.sv
// Scoreboard bench for method_test_driver: a behavioural method model drives busy,
// expected outcomes are queued per run and popped when done rises.
module tb_method_test_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, test_busy, test_return;
    logic dut_reset, test_req, done, pass, timed_out;
    logic busy2, ret2;
    logic dut_reset2, test_req2, done2, pass2, timed_out2;
`ifdef MTD_CYCLES_EN
    logic [31:0] cycles, cycles2;
`endif

    method_test_driver #(.TIMEOUT(1000)) dut (
        .clk(clk), .reset(reset), .dut_reset(dut_reset), .test_req(test_req),
        .test_busy(test_busy), .test_return(test_return), .done(done),
        .pass(pass), .timed_out(timed_out)
`ifdef MTD_CYCLES_EN
        , .cycles(cycles)
`endif
    );

    // Inverted reset window, early request, short grace, zero-latency method.
    method_test_driver #(.RST_START(5), .RST_END(2), .REQ_DELAY(1), .GRACE(2), .TIMEOUT(1000)) dut2 (
        .clk(clk), .reset(reset), .dut_reset(dut_reset2), .test_req(test_req2),
        .test_busy(busy2), .test_return(ret2), .done(done2),
        .pass(pass2), .timed_out(timed_out2)
`ifdef MTD_CYCLES_EN
        , .cycles(cycles2)
`endif
    );

    typedef struct {
        int   done_cyc;
        logic pass;
        logic tout;
        int   ncyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc;
    int   mode;
    int   bleft;
    bit   started;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Method model: 0 = busy 50 cycles from req, 1 = never busy,
    // 2 = busy stuck high, 3 = busy until cycle 1001.
    task automatic drive_model();
        case (mode)
            0: begin
                if (test_req && !started) begin
                    started = 1'b1;
                    bleft   = 50;
                end
                if (bleft > 0) begin
                    test_busy = 1'b1;
                    bleft--;
                end else begin
                    test_busy = 1'b0;
                end
            end
            1: test_busy = 1'b0;
            2: begin
                if (test_req) started = 1'b1;
                test_busy = started;
            end
            default: begin
                if (test_req) started = 1'b1;
                test_busy = started && (cyc < 1001);
            end
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dut_reset"}, dut_reset, 0);
        chk({tag, "_test_req"}, test_req, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_timed_out"}, timed_out, 0);
`ifdef MTD_CYCLES_EN
        chk({tag, "_cycles"}, cycles, 0);
`endif
    endtask

    task automatic model_clear();
        test_busy = 1'b0;
        started   = 1'b0;
        bleft     = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        cyc = 0;
        check_all_zero("reset");
        reset = 1'b0;
    endtask

    // Steps cycles until done, stop_at, or budget; compares per-cycle outputs and
    // pops the scoreboard when done first appears.
    task automatic run(input int id, input int stop_at, input int budget);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        while (!seen && cyc < budget && cyc != stop_at) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("t%0d_done_cycle", id), cyc, e.done_cyc);
                    chk($sformatf("t%0d_pass", id), pass, e.pass);
                    chk($sformatf("t%0d_timed_out", id), timed_out, e.tout);
                    chk($sformatf("t%0d_req_low", id), test_req, 0);
                    chk($sformatf("t%0d_dut_reset_low", id), dut_reset, 0);
`ifdef MTD_CYCLES_EN
                    chk($sformatf("t%0d_cycles", id), cycles, e.ncyc);
`endif
                    repeat (4) @(posedge clk);
                    #1;
                    chk($sformatf("t%0d_done_sticky", id), done, 1);
                    chk($sformatf("t%0d_pass_hold", id), pass, e.pass);
                    chk($sformatf("t%0d_tout_hold", id), timed_out, e.tout);
`ifdef MTD_CYCLES_EN
                    chk($sformatf("t%0d_cycles_frozen", id), cycles, e.ncyc);
`endif
                end
            end else begin
                chk($sformatf("t%0d_dut_reset", id), dut_reset, (cyc >= 3) && (cyc <= 8));
                chk($sformatf("t%0d_test_req", id), test_req, cyc >= 102);
                drive_model();
            end
            if (id == 1) begin
                chk("alt_dut_reset", dut_reset2, 0);
                chk("alt_test_req", test_req2, (cyc >= 5) && (cyc <= 6));
                chk("alt_done", done2, cyc >= 7);
                if (cyc >= 7) begin
                    chk("alt_pass", pass2, 1);
                    chk("alt_timed_out", timed_out2, 0);
`ifdef MTD_CYCLES_EN
                    chk("alt_cycles", cycles2, 2);
`endif
                end
            end
        end
        if (!seen && cyc != stop_at) chk($sformatf("t%0d_done_in_budget", id), done, 1);
    endtask

    task automatic push(input int dc, input logic p, input logic t, input int n);
        exp_t e;
        e.done_cyc = dc;
        e.pass     = p;
        e.tout     = t;
        e.ncyc     = n;
        sb.push_back(e);
    endtask

    initial begin
        reset       = 1'b1;
        test_busy   = 1'b0;
        test_return = 1'b1;
        busy2       = 1'b0;
        ret2        = 1'b1;
        cyc         = 0;
        mode        = 0;
        bleft       = 0;
        started     = 1'b0;

        // T1: 50-cycle method returning true
        mode = 0; test_return = 1'b1;
        do_reset();
        push(153, 1'b1, 1'b0, 51);
        run(1, -1, 1200);

        // T2: same method returning false
        mode = 0; test_return = 1'b0;
        do_reset();
        push(153, 1'b0, 1'b0, 51);
        run(2, -1, 1200);

        // T3: zero-latency method completes after the grace period
        mode = 1; test_return = 1'b1;
        do_reset();
        push(107, 1'b1, 1'b0, 5);
        run(3, -1, 1200);

        // T4: busy stuck high runs into the timeout
        mode = 2; test_return = 1'b1;
        do_reset();
        push(1002, 1'b0, 1'b1, 0);
        run(4, -1, 1200);

        // T5: busy falls on the timeout cycle itself
        mode = 3; test_return = 1'b1;
        do_reset();
        push(1002, 1'b1, 1'b0, 900);
        run(5, -1, 1200);

        // T6: reset while BUSY, then a full rerun
        mode = 0; test_return = 1'b1;
        do_reset();
        run(6, 150, 1200);
        chk("t6_busy_before_reset", test_req, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("t6_mid_reset");
        reset = 1'b0;
        model_clear();
        cyc = 0;
        push(153, 1'b1, 1'b0, 51);
        run(7, -1, 1200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
